// File: rtl/fetch_queue_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package fetch_pkg;

  // Canonical RISC-V nop (addi x0, x0, 0), shown to decode when no entry is valid.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned DEFAULT_DEPTH           = 4;
  localparam int unsigned DEFAULT_MAX_OUTSTANDING = 2;

  // One queued fetch: the instruction word and the PC it was fetched from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Bits needed for a counter that ranges 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int unsigned DEFAULT_COUNT_W = cnt_width(DEFAULT_DEPTH);
  localparam int unsigned DEFAULT_OUTST_W = cnt_width(DEFAULT_MAX_OUTSTANDING);

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the fetch front end's memory, decode and redirect signals.
//
// Handshake: a request transfers on a rising edge where imem_req_valid and
// imem_req_ready are both high; imem_req_valid never depends on
// imem_req_ready. Responses have no back-pressure and return in request
// order. The decode side consumes the head on any edge where fq_valid is
// high and stall_d and redirect_valid are both low.
interface fetch_queue_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall_d;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fq_valid;
  logic [31:0] fq_instr;
  logic [31:0] fq_pc;
  logic [31:0] fq_pc_plus4;

  // Fetch unit side.
  modport master (
    output imem_req_valid, imem_req_addr,
    output fq_valid, fq_instr, fq_pc, fq_pc_plus4,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  stall_d, redirect_valid, redirect_pc
  );

  // Memory / pipeline side.
  modport slave (
    input  imem_req_valid, imem_req_addr,
    input  fq_valid, fq_instr, fq_pc, fq_pc_plus4,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output stall_d, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO of fetch entries; clear beats push and pop.
module fq_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned CW    = cnt_width(DEPTH),
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          clear,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next pointers, occupancy and storage; pointers wrap naturally (DEPTH is 2^PW).
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until counted valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Occupancy never exceeds capacity.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (count_q <= CW'(DEPTH));
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues imem requests with
// credit-based flow control, drops wrong-path responses after a redirect and
// presents queued {instr, pc, pc+4} to decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH           = DEFAULT_DEPTH,
  parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_queue_if.master bus
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned OW = cnt_width(MAX_OUTSTANDING);

  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic [OW-1:0] in_flight;
  logic [31:0]   credit_used;
  logic          req_valid, issue, keep, pop, fq_valid;

  // Issue gating: a request is only sent if its response is guaranteed a queue slot.
  always_comb begin
    in_flight   = outstanding_q - drop_cnt_q;
    credit_used = 32'(count) + 32'(in_flight);
    req_valid   = !reset && !bus.redirect_valid
                  && (outstanding_q < OW'(MAX_OUTSTANDING))
                  && (credit_used < DEPTH);
    issue       = req_valid && bus.imem_req_ready;
    keep        = bus.imem_rsp_valid && (drop_cnt_q == '0) && !bus.redirect_valid;
    fq_valid    = (count != '0);
    pop         = fq_valid && !bus.stall_d && !bus.redirect_valid;
    push_entry  = '{instr: bus.imem_rsp_data, pc: rsp_pc_q};
  end

  // Next PCs and in-flight bookkeeping; a redirect overrides everything else.
  always_comb begin
    fpc_d         = fpc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + OW'(issue) - OW'(bus.imem_rsp_valid);
    drop_cnt_d    = drop_cnt_q;
    if (bus.redirect_valid) begin
      fpc_d      = bus.redirect_pc;
      rsp_pc_d   = bus.redirect_pc;
      // Everything still in flight after this cycle belongs to the old path.
      drop_cnt_d = outstanding_q - OW'(bus.imem_rsp_valid);
    end else begin
      if (issue) begin
        fpc_d = fpc_q + 32'd4;
      end
      if (keep) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
      end else if (bus.imem_rsp_valid) begin
        drop_cnt_d = drop_cnt_q - 1'b1;
      end
    end
  end

  // Fetch state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q         <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fpc_q         <= fpc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // Interface legality: no orphan responses, word-aligned redirect targets.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.imem_rsp_valid && (outstanding_q == '0)));
      assert (!(bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)));
    end
  end

  fq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (keep),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (bus.redirect_valid),
    .count     (count),
    .head      (head)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fpc_q;
  assign bus.fq_valid       = fq_valid;
  assign bus.fq_instr       = fq_valid ? head.instr : NOP_INSTR;
  assign bus.fq_pc          = fq_valid ? head.pc : 32'h0;
  assign bus.fq_pc_plus4    = bus.fq_pc + 32'd4;

endmodule
